// File: rtl/irig_cal_ctrl_if.sv
// Signal bundle between the IRIG-B calibration sequencer and its register/decoder side.
// master = register file / stimulus side, slave = irig_cal_ctrl.
interface irig_cal_ctrl_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 cal_start;
    logic [CNT_WIDTH-1:0] debounce;
    logic                 irig_in;
    logic                 rst_irig;
    logic                 calibrate;
    logic                 cal_busy;
    logic                 cal_done;
    logic [1:0]           cal_err;
    logic [CNT_WIDTH-1:0] zero_count;
    logic [CNT_WIDTH-1:0] one_count;
    logic [CNT_WIDTH-1:0] id_count;
    logic [CNT_WIDTH-1:0] w_min;
    logic [CNT_WIDTH-1:0] w_max;

    modport master (
        output cal_start, debounce, irig_in,
        input  rst_irig, calibrate, cal_busy, cal_done, cal_err,
        input  zero_count, one_count, id_count, w_min, w_max
    );

    modport slave (
        input  cal_start, debounce, irig_in,
        output rst_irig, calibrate, cal_busy, cal_done, cal_err,
        output zero_count, one_count, id_count, w_min, w_max
    );
endinterface

// File: rtl/irig_cal_ctrl.sv
// IRIG-B calibration sequencer: measures high-pulse widths and derives decoder thresholds.
// Define IRIG_CAL_SYNC_EN to pass irig_in through a 2-flop synchronizer first.
module irig_cal_ctrl #(
    parameter int CNT_WIDTH      = 32,
    parameter int NUM_PULSES     = 100,
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic             axi_clock,
    input  logic             rst,
    irig_cal_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {S_IDLE, S_RST, S_ARM, S_MEAS, S_CALC, S_DONE, S_ERR} state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_SPAN    = 2'd2;
    localparam logic [1:0] ERR_OVF     = 2'd3;

    localparam int PC_W = $clog2(NUM_PULSES + 1);
    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int SW   = CNT_WIDTH + 1;
    localparam logic [PC_W-1:0]      PULSE_LAST = PC_W'(NUM_PULSES - 1);
    localparam logic [RC_W-1:0]      RST_LAST   = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TO_LAST    = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] ALL_ONES   = '1;

    state_t               state;
    logic [RC_W-1:0]      rst_cnt;
    logic [PC_W-1:0]      pulse_cnt;
    logic [CNT_WIDTH-1:0] width_cnt, to_cnt, run_min, run_max;
    logic [CNT_WIDTH-1:0] zero_q, one_q, id_q, w_min_q, w_max_q;
    logic                 rst_irig_q, busy_q, done_q;
    logic [1:0]           err_q;

    logic irig_s, irig_d, rise, fall;

`ifdef IRIG_CAL_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge axi_clock) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], bus.irig_in};
    end
    assign irig_s = sync_q[1];
`else
    assign irig_s = bus.irig_in;
`endif

    always_ff @(posedge axi_clock) begin
        if (rst) irig_d <= 1'b0;
        else     irig_d <= irig_s;
    end

    assign rise = irig_s & ~irig_d;
    assign fall = ~irig_s & irig_d;

    // Threshold arithmetic is one bit wider so id_count can saturate instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat(input logic [SW-1:0] v);
        return v[SW-1] ? ALL_ONES : v[CNT_WIDTH-1:0];
    endfunction

    logic [CNT_WIDTH-1:0] span;
    logic [SW-1:0]        zero_sum, one_sum, id_sum;
    assign span     = run_max - run_min;
    assign zero_sum = SW'(run_min) + SW'(span >> 2);
    assign one_sum  = SW'(run_min) + SW'(span >> 1) + SW'(span >> 2);
    assign id_sum   = SW'(run_max) + SW'(span >> 2);

    // NOTE: every register here uses <= so all branches see pre-edge values of state and counters.
    always_ff @(posedge axi_clock) begin
        if (rst) begin
            state      <= S_IDLE;
            rst_cnt    <= '0;
            pulse_cnt  <= '0;
            width_cnt  <= '0;
            to_cnt     <= '0;
            run_min    <= '0;
            run_max    <= '0;
            zero_q     <= '0;
            one_q      <= '0;
            id_q       <= '0;
            w_min_q    <= '0;
            w_max_q    <= '0;
            rst_irig_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= ERR_NONE;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.cal_start) begin
                        state      <= S_RST;
                        rst_irig_q <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= ERR_NONE;
                        rst_cnt    <= '0;
                        pulse_cnt  <= '0;
                        width_cnt  <= '0;
                        to_cnt     <= '0;
                        run_min    <= ALL_ONES;
                        run_max    <= '0;
                    end
                end
                S_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        rst_irig_q <= 1'b0;
                        state      <= S_ARM;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                S_ARM: begin
                    // A pulse already high on entry has no rise and is skipped.
                    if (rise) begin
                        state     <= S_MEAS;
                        width_cnt <= CNT_WIDTH'(1);
                        to_cnt    <= '0;
                    end else if (fall) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        state  <= S_ERR;
                        busy_q <= 1'b0;
                        err_q  <= ERR_TIMEOUT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_MEAS: begin
                    // The fall branch comes first so a final fall beats a coincident timeout.
                    if (fall) begin
                        to_cnt <= '0;
                        if (width_cnt >= bus.debounce) begin
                            if (width_cnt < run_min) run_min <= width_cnt;
                            if (width_cnt > run_max) run_max <= width_cnt;
                            pulse_cnt <= pulse_cnt + 1'b1;
                            if (pulse_cnt == PULSE_LAST) state <= S_CALC;
                        end
                    end else if (rise) begin
                        width_cnt <= CNT_WIDTH'(1);
                        to_cnt    <= '0;
                    end else if (irig_s && width_cnt == ALL_ONES) begin
                        state  <= S_ERR;
                        busy_q <= 1'b0;
                        err_q  <= ERR_OVF;
                    end else if (to_cnt == TO_LAST) begin
                        state  <= S_ERR;
                        busy_q <= 1'b0;
                        err_q  <= ERR_TIMEOUT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                        if (irig_s) width_cnt <= width_cnt + 1'b1;
                    end
                end
                S_CALC: begin
                    busy_q <= 1'b0;
                    if (span < (run_min >> 1)) begin
                        state <= S_ERR;
                        err_q <= ERR_SPAN;
                    end else begin
                        state   <= S_DONE;
                        done_q  <= 1'b1;
                        zero_q  <= sat(zero_sum);
                        one_q   <= sat(one_sum);
                        id_q    <= sat(id_sum);
                        w_min_q <= run_min;
                        w_max_q <= run_max;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rst_irig   = rst_irig_q;
    assign bus.calibrate  = busy_q;
    assign bus.cal_busy   = busy_q;
    assign bus.cal_done   = done_q;
    assign bus.cal_err    = err_q;
    assign bus.zero_count = zero_q;
    assign bus.one_count  = one_q;
    assign bus.id_count   = id_q;
    assign bus.w_min      = w_min_q;
    assign bus.w_max      = w_max_q;
endmodule

// File: tb/tb_irig_cal_ctrl.sv
// Directed bench for irig_cal_ctrl: calibration, glitches, timeout, bad span, restart, reset.
module tb_irig_cal_ctrl;
    localparam int CW = 32;

    logic axi_clock = 1'b0;
    logic rst       = 1'b1;

    irig_cal_ctrl_if #(.CNT_WIDTH(CW)) bus ();

    irig_cal_ctrl #(
        .CNT_WIDTH(CW), .NUM_PULSES(6), .RST_CYCLES(4), .TIMEOUT_CYCLES(1000)
    ) dut (
        .axi_clock(axi_clock),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 axi_clock = ~axi_clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [5*CW-1:0] res;
    assign res = {bus.zero_count, bus.one_count, bus.id_count, bus.w_min, bus.w_max};

    logic [4*CW+CW+5:0] all_out;
    assign all_out = {bus.rst_irig, bus.calibrate, bus.cal_busy, bus.cal_done, bus.cal_err, res};

    localparam logic [5*CW-1:0] RES_A = {32'd35, 32'd65, 32'd95, 32'd20, 32'd80};
    localparam logic [5*CW-1:0] RES_B = {32'd45, 32'd75, 32'd105, 32'd30, 32'd90};
    localparam logic [3:0] ST_CALC = 4'b1_0_00;   // {busy, done, err}
    localparam logic [3:0] ST_DONE = 4'b0_1_00;
    localparam logic [3:0] ST_SPAN = 4'b0_0_10;

    int pat_a [6] = '{20, 50, 80, 20, 50, 80};
    int pat_b [6] = '{30, 60, 90, 30, 60, 90};
    int pat_s [6] = '{50, 50, 50, 50, 50, 50};

    task automatic start_cal();
        @(negedge axi_clock);
        bus.cal_start = 1'b1;
        @(negedge axi_clock);
        bus.cal_start = 1'b0;
    endtask

    // Counts negedges with rst_irig high; returns on the first low sample after the high run.
    task automatic wait_rst_release(output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus.rst_irig) n++;
            else if (n > 0) break;
            @(negedge axi_clock);
        end
    endtask

    task automatic send_pulse(input int w, input int gap);
        @(negedge axi_clock);
        bus.irig_in = 1'b1;
        repeat (w) @(negedge axi_clock);
        bus.irig_in = 1'b0;
        repeat (gap) @(negedge axi_clock);
    endtask

    // Final pulse: samples {busy, done, err} one and two clocks after the fall is seen.
    task automatic send_last(input int w, output logic [3:0] a, output logic [3:0] b);
        @(negedge axi_clock);
        bus.irig_in = 1'b1;
        repeat (w) @(negedge axi_clock);
        bus.irig_in = 1'b0;
        @(negedge axi_clock);
        a = {bus.cal_busy, bus.cal_done, bus.cal_err};
        @(negedge axi_clock);
        b = {bus.cal_busy, bus.cal_done, bus.cal_err};
    endtask

    task automatic run_pattern(input int w [6], output logic [3:0] a, output logic [3:0] b);
        for (int i = 0; i < 5; i++) send_pulse(w[i], 100 - w[i]);
        send_last(w[5], a, b);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge axi_clock);
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int n;
        logic [3:0] a, b;
        start_cal();
        n_cmp++;
        if ({bus.calibrate, bus.cal_busy, bus.cal_done} !== 3'b110) begin
            n_bad++;
            $display("FAIL basic_busy: got %b want 110", {bus.calibrate, bus.cal_busy, bus.cal_done});
        end
        wait_rst_release(n);
        n_cmp++;
        if (n !== 4) begin
            n_bad++;
            $display("FAIL basic_rst_len: got %0d want 4", n);
        end
        run_pattern(pat_a, a, b);
        n_cmp++;
        if (a !== ST_CALC) begin
            n_bad++;
            $display("FAIL basic_calc_cycle: got %b want %b", a, ST_CALC);
        end
        n_cmp++;
        if (b !== ST_DONE) begin
            n_bad++;
            $display("FAIL basic_done_cycle: got %b want %b", b, ST_DONE);
        end
        n_cmp++;
        if (res !== RES_A) begin
            n_bad++;
            $display("FAIL basic_results: got %h want %h", res, RES_A);
        end
    endtask

    task automatic test_glitch();
        int n;
        logic [3:0] a, b;
        start_cal();
        wait_rst_release(n);
        for (int i = 0; i < 5; i++) begin
            send_pulse(3, 40);
            send_pulse(pat_a[i], 100 - pat_a[i]);
        end
        send_pulse(3, 40);
        send_last(pat_a[5], a, b);
        n_cmp++;
        if (a !== ST_CALC) begin
            n_bad++;
            $display("FAIL glitch_calc_cycle: got %b want %b", a, ST_CALC);
        end
        n_cmp++;
        if (b !== ST_DONE) begin
            n_bad++;
            $display("FAIL glitch_done_cycle: got %b want %b", b, ST_DONE);
        end
        n_cmp++;
        if (res !== RES_A) begin
            n_bad++;
            $display("FAIL glitch_results: got %h want %h", res, RES_A);
        end
    endtask

    task automatic test_timeout();
        int n, idle;
        start_cal();
        wait_rst_release(n);
        idle = 0;
        while (idle < 2000) begin
            @(negedge axi_clock);
            idle++;
            if (bus.cal_err !== 2'd0) break;
        end
        n_cmp++;
        if (idle !== 1000) begin
            n_bad++;
            $display("FAIL timeout_cycles: got %0d want 1000", idle);
        end
        n_cmp++;
        if ({bus.cal_busy, bus.calibrate, bus.cal_done, bus.cal_err} !== 5'b000_01) begin
            n_bad++;
            $display("FAIL timeout_status: got %b want 00001",
                     {bus.cal_busy, bus.calibrate, bus.cal_done, bus.cal_err});
        end
        n_cmp++;
        if (res !== RES_A) begin
            n_bad++;
            $display("FAIL timeout_retained: got %h want %h", res, RES_A);
        end
    endtask

    task automatic test_bad_span();
        int n;
        logic [3:0] a, b;
        start_cal();
        wait_rst_release(n);
        run_pattern(pat_s, a, b);
        n_cmp++;
        if (b !== ST_SPAN) begin
            n_bad++;
            $display("FAIL span_status: got %b want %b", b, ST_SPAN);
        end
        n_cmp++;
        if (res !== RES_A) begin
            n_bad++;
            $display("FAIL span_retained: got %h want %h", res, RES_A);
        end
    endtask

    task automatic test_restart();
        int n;
        logic [3:0] a, b;
        start_cal();
        wait_rst_release(n);
        send_pulse(pat_a[0], 100 - pat_a[0]);
        send_pulse(pat_a[1], 40);
        bus.cal_start = 1'b1;
        @(negedge axi_clock);
        bus.cal_start = 1'b0;
        @(negedge axi_clock);
        n_cmp++;
        if ({bus.rst_irig, bus.cal_busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL restart_ignored: got %b want 01", {bus.rst_irig, bus.cal_busy});
        end
        for (int i = 2; i < 5; i++) send_pulse(pat_a[i], 100 - pat_a[i]);
        send_last(pat_a[5], a, b);
        n_cmp++;
        if (b !== ST_DONE || res !== RES_A) begin
            n_bad++;
            $display("FAIL restart_first_run: got %b/%h want %b/%h", b, res, ST_DONE, RES_A);
        end
        start_cal();
        n_cmp++;
        if ({bus.cal_done, bus.cal_busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL restart_done_clear: got %b want 01", {bus.cal_done, bus.cal_busy});
        end
        wait_rst_release(n);
        run_pattern(pat_b, a, b);
        n_cmp++;
        if (b !== ST_DONE) begin
            n_bad++;
            $display("FAIL restart_done_cycle: got %b want %b", b, ST_DONE);
        end
        n_cmp++;
        if (res !== RES_B) begin
            n_bad++;
            $display("FAIL restart_results: got %h want %h", res, RES_B);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [3:0] a, b;
        start_cal();
        wait_rst_release(n);
        for (int i = 0; i < 3; i++) send_pulse(pat_a[i], 100 - pat_a[i]);
        rst = 1'b1;
        @(negedge axi_clock);
        n_cmp++;
        if (all_out !== '0) begin
            n_bad++;
            $display("FAIL midrst_outputs: got %h want 0", all_out);
        end
        rst = 1'b0;
        start_cal();
        wait_rst_release(n);
        n_cmp++;
        if (n !== 4) begin
            n_bad++;
            $display("FAIL midrst_rst_len: got %0d want 4", n);
        end
        run_pattern(pat_a, a, b);
        n_cmp++;
        if (b !== ST_DONE || res !== RES_A) begin
            n_bad++;
            $display("FAIL midrst_rerun: got %b/%h want %b/%h", b, res, ST_DONE, RES_A);
        end
    endtask

    initial begin
        bus.cal_start = 1'b0;
        bus.debounce  = 32'd5;
        bus.irig_in   = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_timeout();
        test_bad_span();
        test_restart();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
